load_unit: RTL
==============

// Module: load_unit
// PURPOSE
//   Memory-read sequencer for OP_LOAD instructions. Issues a req/ack read to data
//   memory at the address held in MAR, then returns the read word and a one-cycle
//   completion strobe. Sits directly upstream of the hub, driving its
//   load_to_mdr / is_loaded inputs. While is_loaded is low the hub stalls PC.
// PARAMETERS
//   OP_LOAD      8'h02  opcode value in instruction[15:8] that selects a load
//   DATA_W       16     width of memory data / load_to_mdr
//   ADDR_W       16     width of memory address / MAR
//   TIMEOUT      15     max cycles in REQ without ack before abort (>=1)
// PORTS
//   clk          in   1       system clock, all state on rising edge
//   rst_n        in   1       asynchronous active-low reset
//   instruction  in   16      current instruction; opcode = instruction[15:8]
//   mar          in   ADDR_W  memory address register value (load address)
//   mem_rd_req   out  1       read request to data memory
//   mem_addr     out  ADDR_W  read address, stable while mem_rd_req high
//   mem_rd_ack   in   1       memory ack; mem_rd_data valid in same cycle
//   mem_rd_data  in   DATA_W  read data from memory
//   load_to_mdr  out  DATA_W  captured read word, to hub
//   is_loaded    out  1       one-cycle completion strobe, to hub
//   load_err     out  1       one-cycle strobe: load aborted on timeout
// BEHAVIOUR
//   - Reset (rst_n low, async): state=IDLE, mem_rd_req=0, mem_addr=0,
//     load_to_mdr=0, is_loaded=0, load_err=0, timeout counter=0.
//     Reset mid-transaction drops req immediately; no completion reported.
//   - All outputs are registered.
//   - FSM states: IDLE, REQ, DONE, DRAIN.
//   - IDLE: if opcode==OP_LOAD: mem_addr<=mar, mem_rd_req<=1, cnt<=0, ->REQ.
//     Any other opcode: stay. mem_rd_ack in IDLE is ignored.
//   - REQ: mem_rd_req and mem_addr held constant. cnt increments each cycle.
//     On mem_rd_ack=1:
//       load_to_mdr<=mem_rd_data, mem_rd_req<=0.
//       If opcode still OP_LOAD: is_loaded<=1, ->DONE.
//       Otherwise: ->IDLE, no strobe.
//     On cnt==TIMEOUT-1 without ack:
//       mem_rd_req<=0, load_to_mdr<=0, is_loaded<=1, load_err<=1, ->DONE
//       (CPU advances; error reported). Ack and timeout in the same cycle:
//       ack wins, no error.
//   - Opcode leaving OP_LOAD while in REQ (flush): request still completes on the
//     bus; data is discarded per above. A timeout in this case returns ->IDLE
//     with no strobes.
//   - DONE: is_loaded and load_err are high for exactly this one cycle; both clear
//     on the next edge, ->IDLE. load_to_mdr holds its value until the next
//     completion.
//   - Back-to-back loads: the next instruction is seen in IDLE the cycle after
//     DONE.
//   - Latency, ack on first REQ cycle: opcode seen at edge 0, req high after
//     edge 0, ack sampled at edge 1, is_loaded high after edge 1 (one cycle).
//     Minimum 3 cycles per load, IDLE to IDLE.
//   - DRAIN: reserved, unreachable; decodes to IDLE.
//   - Counter width is $clog2(TIMEOUT+1). No arithmetic on data/address.
// TESTING
//   1. Reset: rst_n=0 asynchronously mid-REQ
//      -> req/is_loaded/load_err/load_to_mdr all 0 immediately, state IDLE.
//   2. Basic load: instr=16'h02xx, mar=16'h0040, ack on first REQ cycle with
//      data 16'hBEEF -> mem_addr=16'h0040, load_to_mdr=16'hBEEF,
//      is_loaded high exactly 1 cycle, 3 cycles total.
//   3. Wait states: ack after 5 REQ cycles, mar changed to 16'h0099 during REQ
//      -> mem_addr stays 16'h0040, req high 5 cycles, one is_loaded strobe.
//   4. Timeout: TIMEOUT=15, no ack -> req drops after 15 cycles,
//      is_loaded=1 and load_err=1 same cycle, load_to_mdr=0.
//   5. Flush: opcode changes to non-load during REQ, then ack with 16'h1234
//      -> no is_loaded; load_to_mdr=16'h1234; back to IDLE.
//   6. Back-to-back: two consecutive loads (16'h0010 -> 16'hAAAA,
//      16'h0011 -> 16'h5555) -> two separate 1-cycle strobes, correct data each.

Source files
------------

// File: rtl/load_unit.sv
// load_unit: memory-read sequencer for OP_LOAD instructions; issues a req/ack read at MAR
// and hands the word to the hub with a one-cycle completion (or timeout-error) strobe.
module load_unit #(
   parameter logic [7:0] OP_LOAD = 8'h02,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       instruction,
   input  logic [ADDR_W-1:0] mar,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rd_ack,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [DATA_W-1:0] load_to_mdr,
   output logic              is_loaded,
   output logic              load_err
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;
   state_t state_q, state_d;
   logic req_q, req_d, ld_q, ld_d, err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic is_load, timeout, unused_low;
   assign unused_low = ^instruction[7:0];
   always_comb begin
      is_load = instruction[15:8] == OP_LOAD;
      timeout = cnt_q == CW'(TIMEOUT - 1);
      state_d = state_q;
      req_d = req_q;
      addr_d = addr_q;
      mdr_d = mdr_q;
      cnt_d = cnt_q;
      ld_d = 1'b0;
      err_d = 1'b0;
      case (state_q)
         IDLE: if (is_load) begin
            addr_d = mar;
            req_d = 1'b1;
            cnt_d = '0;
            state_d = REQ;
         end
         REQ: begin
            cnt_d = cnt_q + CW'(1);
            if (mem_rd_ack) begin
               // a flushed load still finishes on the bus but reports nothing
               mdr_d = mem_rd_data;
               req_d = 1'b0;
               ld_d = is_load;
               state_d = is_load ? DONE : IDLE;
            end else if (timeout) begin
               mdr_d = is_load ? '0 : mdr_q;
               req_d = 1'b0;
               ld_d = is_load;
               err_d = is_load;
               state_d = is_load ? DONE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q <= 1'b0;
         addr_q <= '0;
         mdr_q <= '0;
         cnt_q <= '0;
         ld_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q <= req_d;
         addr_q <= addr_d;
         mdr_q <= mdr_d;
         cnt_q <= cnt_d;
         ld_q <= ld_d;
         err_q <= err_d;
      end
   end
   assign mem_rd_req = req_q;
   assign mem_addr = addr_q;
   assign load_to_mdr = mdr_q;
   assign is_loaded = ld_q;
   assign load_err = err_q;
endmodule
